// File: rtl/prbs26_checker.sv
// Receive-side checker for the 26-bit Galois PRBS (x^26+x^8+x^7+x+1): self-synchronises on the
// serial stream, declares lock, counts bit errors and drops lock when errors get too dense.
module prbs26_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int WIN         = 1024,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_din,
    input  logic             i_din_valid,
    input  logic             i_clr_cnt,
    input  logic             i_resync,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam int WIN_W  = $clog2(WIN);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        FILL,
        VERIFY,
        LOCKED
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [25:0]        r_hist;
    logic [4:0]         r_fillCnt;
    logic [7:0]         r_matchCnt;
    logic [WIN_W-1:0]   r_winPos;
    logic [WERR_W-1:0]  r_winErr;
    logic [CNT_W-1:0]   r_errCnt;
    logic [CNT_W-1:0]   r_bitCnt;
    logic               r_errPulse;
    logic               r_locked;

    logic               w_pred;
    logic               w_lineErr;
    logic               w_match;
    logic               w_fillDone;
    logic               w_lockHit;
    logic               w_winEnd;
    logic               w_lossHit;
    logic               w_checkBit;
    logic [WERR_W-1:0]  w_winErrNext;

    // r_hist[0] is the newest bit, so r_hist[k-1] holds history stage h[k].
    assign w_pred       = r_hist[25] ^ r_hist[24] ^ r_hist[18] ^ r_hist[17];
    assign w_lineErr    = i_din ^ w_pred;
    assign w_match      = !w_lineErr && (r_hist != '0);
    assign w_fillDone   = (r_fillCnt == 5'd25);
    assign w_lockHit    = w_match && (r_matchCnt == 8'(LOCK_CNT - 1));
    assign w_winEnd     = (r_winPos == WIN_W'(WIN - 1));
    assign w_winErrNext = r_winErr + {{(WERR_W-1){1'b0}}, w_lineErr};
    assign w_lossHit    = w_lineErr && (w_winErrNext >= WERR_W'(LOSS_THRESH));
    assign w_checkBit   = i_din_valid && (r_state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (i_din_valid) begin
            case (r_state)
                FILL:    if (w_fillDone) w_nextState = VERIFY;
                VERIFY:  if (w_lockHit)  w_nextState = LOCKED;
                LOCKED:  if (w_lossHit)  w_nextState = FILL;
                default: w_nextState = FILL;
            endcase
        end
        if (i_resync) begin
            w_nextState = FILL;
        end
    end

    // Once locked, the history follows the prediction rather than the line, so a single
    // flipped bit is counted once instead of corrupting the next few predictions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist     <= '0;
            r_fillCnt  <= '0;
            r_matchCnt <= '0;
            r_winPos   <= '0;
            r_winErr   <= '0;
            r_errCnt   <= '0;
            r_bitCnt   <= '0;
            r_errPulse <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_errPulse <= w_checkBit && w_lineErr;
            r_locked   <= (w_nextState == LOCKED);

            if (i_din_valid) begin
                if (r_state == LOCKED) begin
                    r_hist <= {r_hist[24:0], w_pred};
                end else begin
                    r_hist <= {r_hist[24:0], i_din};
                end
            end

            if (i_resync || (w_checkBit && w_lossHit)) begin
                r_fillCnt <= '0;
            end else if (i_din_valid && (r_state == FILL)) begin
                r_fillCnt <= w_fillDone ? 5'd0 : r_fillCnt + 5'd1;
            end

            if (i_din_valid) begin
                if (r_state == FILL) begin
                    r_matchCnt <= '0;
                end else if (r_state == VERIFY) begin
                    r_matchCnt <= w_match ? r_matchCnt + 8'd1 : 8'd0;
                end
            end

            // The window position wraps on its own because WIN is a power of two.
            if (i_din_valid) begin
                if (r_state == VERIFY) begin
                    r_winPos <= '0;
                    r_winErr <= '0;
                end else if (r_state == LOCKED) begin
                    r_winPos <= r_winPos + WIN_W'(1);
                    r_winErr <= w_winEnd ? '0 : w_winErrNext;
                end
            end

            if (i_clr_cnt) begin
                r_errCnt <= '0;
                r_bitCnt <= '0;
            end else if (w_checkBit) begin
                if (~&r_bitCnt) begin
                    r_bitCnt <= r_bitCnt + CNT_W'(1);
                end
                if (w_lineErr && ~&r_errCnt) begin
                    r_errCnt <= r_errCnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_locked    = r_locked;
    assign o_err_pulse = r_errPulse;
    assign o_err_cnt   = r_errCnt;
    assign o_bit_cnt   = r_bitCnt;

endmodule

// File: tb/tb_prbs26_checker.sv
// Scoreboard bench for prbs26_checker: a behavioural model predicts every cycle's outputs,
// directed scenarios cover lock timing, error bursts and window edges, then random traffic.
module tb_prbs26_checker;

    localparam int LOCK_CNT    = 32;
    localparam int WIN         = 1024;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_W       = 32;
    localparam int STREAM_LEN  = 16384;
    localparam int M_FILL      = 0;
    localparam int M_VERIFY    = 1;
    localparam int M_LOCKED    = 2;
    localparam longint SAT     = (longint'(1) << CNT_W) - 1;

    typedef struct packed {
        logic             locked;
        logic             errPulse;
        logic [CNT_W-1:0] errCnt;
        logic [CNT_W-1:0] bitCnt;
    } expect_t;

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             dinValid;
    logic             clrCnt;
    logic             resync;
    logic             locked;
    logic             errPulse;
    logic [CNT_W-1:0] errCnt;
    logic [CNT_W-1:0] bitCnt;

    expect_t expQ[$];
    int      checks   = 0;
    int      failures = 0;
    bit      stream[STREAM_LEN];
    int      streamIdx;

    int      mState;
    bit      mHist[26];
    int      mFill;
    int      mMatch;
    int      mWinPos;
    int      mWinErr;
    longint  mErrCnt;
    longint  mBitCnt;
    bit      mLocked;
    bit      mPulse;

    prbs26_checker #(
        .LOCK_CNT    (LOCK_CNT),
        .WIN         (WIN),
        .LOSS_THRESH (LOSS_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_din       (din),
        .i_din_valid (dinValid),
        .i_clr_cnt   (clrCnt),
        .i_resync    (resync),
        .o_locked    (locked),
        .o_err_pulse (errPulse),
        .o_err_cnt   (errCnt),
        .o_bit_cnt   (bitCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelReset();
        mState = M_FILL;
        foreach (mHist[k]) mHist[k] = 1'b0;
        mFill   = 0;
        mMatch  = 0;
        mWinPos = 0;
        mWinErr = 0;
        mErrCnt = 0;
        mBitCnt = 0;
        mLocked = 1'b0;
        mPulse  = 1'b0;
    endfunction

    function automatic void modelShift(input bit b);
        for (int k = 25; k > 0; k--) mHist[k] = mHist[k-1];
        mHist[0] = b;
    endfunction

    // mHist[0] is h[1] (newest); prediction from the stream recurrence s[t+26]=s[t]^s[t+1]^s[t+7]^s[t+8].
    function automatic void modelStep(input bit rstnB, input bit d, input bit v, input bit clr, input bit rs);
        bit pred;
        bit err;
        bit anyOne;
        if (!rstnB) begin
            modelReset();
            return;
        end
        mPulse = 1'b0;
        if (v) begin
            pred   = mHist[25] ^ mHist[24] ^ mHist[18] ^ mHist[17];
            anyOne = 1'b0;
            foreach (mHist[k]) if (mHist[k]) anyOne = 1'b1;
            case (mState)
                M_FILL: begin
                    modelShift(d);
                    mFill++;
                    if (mFill == 26) begin
                        mState = M_VERIFY;
                        mMatch = 0;
                    end
                end
                M_VERIFY: begin
                    modelShift(d);
                    if (d == pred && anyOne) begin
                        mMatch++;
                        if (mMatch == LOCK_CNT) begin
                            mState  = M_LOCKED;
                            mWinPos = 0;
                            mWinErr = 0;
                        end
                    end else begin
                        mMatch = 0;
                    end
                end
                default: begin
                    modelShift(pred);
                    err = (d != pred);
                    if (!clr) begin
                        if (mBitCnt < SAT) mBitCnt++;
                        if (err && mErrCnt < SAT) mErrCnt++;
                    end
                    mPulse = err;
                    if (err) mWinErr++;
                    mWinPos++;
                    if (mWinErr >= LOSS_THRESH) begin
                        mState = M_FILL;
                        mFill  = 0;
                    end else if (mWinPos == WIN) begin
                        mWinPos = 0;
                        mWinErr = 0;
                    end
                end
            endcase
        end
        if (clr) begin
            mErrCnt = 0;
            mBitCnt = 0;
        end
        if (rs) begin
            mState = M_FILL;
            mFill  = 0;
        end
        mLocked = (mState == M_LOCKED);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rstnB, input bit d, input bit v, input bit clr, input bit rs);
        expect_t e;
        @(negedge clk);
        rst_n    = rstnB;
        din      = d;
        dinValid = v;
        clrCnt   = clr;
        resync   = rs;
        modelStep(rstnB, d, v, clr, rs);
        e.locked   = mLocked;
        e.errPulse = mPulse;
        e.errCnt   = mErrCnt[CNT_W-1:0];
        e.bitCnt   = mBitCnt[CNT_W-1:0];
        expQ.push_back(e);
    endtask

    task automatic sendBit(input bit flip, input bit clr, input bit rs);
        if (streamIdx >= STREAM_LEN) begin
            $display("[TB] FAIL stream_bounds: index %0d, limit %0d", streamIdx, STREAM_LEN);
            $fatal(1, "[TB] stream exhausted");
        end
        applyStimulus(1'b1, stream[streamIdx] ^ flip, 1'b1, clr, rs);
        streamIdx++;
    endtask

    task automatic sendIdle();
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sampleAfterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_locked",    locked,   e.locked);
                checkOutput("sb_err_pulse", errPulse, e.errPulse);
                checkOutput("sb_err_cnt",   errCnt,   e.errCnt);
                checkOutput("sb_bit_cnt",   bitCnt,   e.bitCnt);
            end
        end
    end

    initial begin : stimulus
        bit v;
        bit clr;
        bit rs;
        bit flip;
        bit rstnB;
        rst_n = 1'b0; din = 1'b0; dinValid = 1'b0; clrCnt = 1'b0; resync = 1'b0;
        for (int t = 0; t < 25; t++) stream[t] = 1'b0;
        stream[25] = 1'b1;
        for (int t = 0; t + 26 < STREAM_LEN; t++)
            stream[t+26] = stream[t] ^ stream[t+1] ^ stream[t+7] ^ stream[t+8];
        modelReset();

        // Clean stream from reset: lock exactly at the 58th valid bit.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        streamIdx = 0;
        repeat (57) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("lock_not_at_57", locked, 0);
        sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("lock_at_58", locked, 1);
        checkOutput("err_cnt_at_lock", errCnt, 0);
        checkOutput("bit_cnt_at_lock", bitCnt, 0);
        repeat (5) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("bit_cnt_after_5", bitCnt, 5);

        // Single line error at bit_cnt=100.
        while (mBitCnt != 100) sendBit(1'b0, 1'b0, 1'b0);
        sendBit(1'b1, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("single_err_pulse", errPulse, 1);
        checkOutput("single_err_cnt", errCnt, 1);
        checkOutput("single_err_locked", locked, 1);
        sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("pulse_one_cycle", errPulse, 0);
        repeat (100) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("no_further_errs", errCnt, 1);

        // Eight errors spaced 10 apart in a fresh window: lock drops on the 8th.
        while (mWinPos != 0) sendBit(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            sendBit(1'b1, 1'b0, 1'b0);
            if (n < 7) begin
                sampleAfterEdge();
                checkOutput("burst_lock_held", locked, 1);
                repeat (9) sendBit(1'b0, 1'b0, 1'b0);
            end
        end
        sampleAfterEdge();
        checkOutput("burst_lost_lock", locked, 0);
        checkOutput("burst_err_cnt", errCnt, 9);
        repeat (57) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("relock_not_at_57", locked, 0);
        sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("relock_at_58", locked, 1);

        // Seven errors in each of two consecutive windows keep lock.
        sendBit(1'b0, 1'b1, 1'b0);
        sampleAfterEdge();
        checkOutput("clr_bit_cnt", bitCnt, 0);
        checkOutput("clr_err_cnt", errCnt, 0);
        repeat (2 * WIN) sendBit(mWinPos >= 100 && mWinPos <= 160 && mWinPos % 10 == 0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("two_window_err_cnt", errCnt, 14);
        checkOutput("two_window_locked", locked, 1);

        // 8th error lands on the rollover bit: loss wins over the window reset.
        while (mWinPos != WIN - 1) sendBit(mWinPos >= 200 && mWinPos <= 260 && mWinPos % 10 == 0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("pre_rollover_locked", locked, 1);
        sendBit(1'b1, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("loss_beats_rollover", locked, 0);
        checkOutput("loss_err_cnt", errCnt, 22);

        // Resync drops lock but keeps counters.
        repeat (58) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("relock_after_boundary", locked, 1);
        sendBit(1'b0, 1'b0, 1'b1);
        sampleAfterEdge();
        checkOutput("resync_drops_lock", locked, 0);
        checkOutput("resync_keeps_err_cnt", errCnt, 22);
        repeat (58) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("relock_after_resync", locked, 1);

        // All-zero line never locks; generator stream afterwards locks in 58 bits.
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (200) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("zero_line_no_lock", locked, 0);
        streamIdx = 0;
        repeat (57) sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("zero_then_stream_57", locked, 0);
        sendBit(1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("zero_then_stream_58", locked, 1);

        // Valid toggling 1/0: lock after 58 valid bits, idle bits carry garbage.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        streamIdx = 0;
        for (int n = 0; n < 58; n++) begin
            sendBit(1'b0, 1'b0, 1'b0);
            if (n == 56) begin
                sampleAfterEdge();
                checkOutput("toggle_not_at_57", locked, 0);
            end
            if (n == 57) begin
                sampleAfterEdge();
                checkOutput("toggle_lock_at_58", locked, 1);
            end
            sendIdle();
        end
        repeat (3) sendBit(1'b0, 1'b0, 1'b0);
        sendBit(1'b1, 1'b1, 1'b0);
        sampleAfterEdge();
        checkOutput("clr_with_err_pulse", errPulse, 1);
        checkOutput("clr_with_err_err_cnt", errCnt, 0);
        checkOutput("clr_with_err_bit_cnt", bitCnt, 0);
        sendBit(1'b1, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("err_before_reset", errCnt, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_err_pulse", errPulse, 0);
        checkOutput("reset_err_cnt", errCnt, 0);
        checkOutput("reset_bit_cnt", bitCnt, 0);

        // Random traffic: gaps, line errors, occasional clears, resyncs and resets.
        streamIdx = 0;
        repeat (3000) begin
            v     = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 299) == 0);
            rs    = ($urandom_range(0, 699) == 0);
            flip  = ($urandom_range(0, 149) == 0);
            rstnB = ($urandom_range(0, 1499) != 0);
            if (v) begin
                applyStimulus(rstnB, stream[streamIdx] ^ flip, 1'b1, clr, rs);
                streamIdx++;
            end else begin
                applyStimulus(rstnB, 1'($urandom_range(0, 1)), 1'b0, clr, rs);
            end
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sampleAfterEdge();
        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
